// File: rtl/crc_out_arbiter.sv
// rtl/crc_out_arbiter.sv - round-robin arbiter sharing one registered CRC result port
module crc_out_arbiter #(
  parameter int pNREQ = 4,
  parameter int pSW   = 2,
  parameter int pDW   = 60,
  parameter int pGAP  = 2
) (
  input  logic                   clk_3,
  input  logic                   rst_n,
  input  logic                   arb_en,
  input  logic [pNREQ-1:0]       req_valid,
  input  logic [pNREQ*pDW-1:0]   req_data,
  output logic [pNREQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [pDW-1:0]         out,
  output logic [pSW-1:0]         out_src,
  output logic                   busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GAP  = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [3:0]     gap_cnt_q, gap_cnt_d;
  logic [pSW-1:0] rr_ptr_q, rr_ptr_d;
  logic           out_valid_q, out_valid_d;
  logic [pDW-1:0] out_q, out_d;
  logic [pSW-1:0] out_src_q, out_src_d;
  logic           busy_q, busy_d;

  logic           found;
  logic [pSW-1:0] winner;
  int             idx;
  logic           accept;
  logic [pDW-1:0] win_data;

  // First valid source at or after rr_ptr, wrapping modulo pNREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < pNREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % pNREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx[pSW-1:0];
      end
    end
  end

  assign accept = rst_n && arb_en && (state_q == ST_IDLE) && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < pNREQ; i++) begin
      if (req_ready[i]) win_data = win_data | req_data[i*pDW +: pDW];
    end
  end

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    busy_d      = busy_q;
    out_valid_d = accept;
    out_d       = accept ? win_data : '0;
    out_src_d   = accept ? winner : '0;
    if (accept) begin
      rr_ptr_d = (winner == pSW'(pNREQ-1)) ? '0 : winner + pSW'(1);
      if (pGAP > 0) begin
        state_d   = ST_GAP;
        gap_cnt_d = 4'(pGAP);
        busy_d    = 1'b1;
      end
    end else if (state_q == ST_GAP) begin
      gap_cnt_d = gap_cnt_q - 4'd1;
      if (gap_cnt_q == 4'd1) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_3) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_src_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_src_q   <= out_src_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_src   = out_src_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_crc_out_arbiter.sv
// tb/tb_crc_out_arbiter.sv - bench for crc_out_arbiter at pGAP 2, 0 and 4
module tb_crc_out_arbiter;

  logic         clk_3 = 1'b0;
  logic         rst_n;
  logic         arb_en;
  logic [3:0]   req_valid;
  logic [239:0] req_data;

  logic [3:0]   rdy [3];
  logic         ov  [3];
  logic [59:0]  o   [3];
  logic [1:0]   os  [3];
  logic         bz  [3];

  always #5 clk_3 = ~clk_3;

  crc_out_arbiter #(.pNREQ(4), .pSW(2), .pDW(60), .pGAP(2)) u_g2 (
    .clk_3(clk_3), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy[0]), .out_valid(ov[0]), .out(o[0]), .out_src(os[0]), .busy(bz[0]));
  crc_out_arbiter #(.pNREQ(4), .pSW(2), .pDW(60), .pGAP(0)) u_g0 (
    .clk_3(clk_3), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy[1]), .out_valid(ov[1]), .out(o[1]), .out_src(os[1]), .busy(bz[1]));
  crc_out_arbiter #(.pNREQ(4), .pSW(2), .pDW(60), .pGAP(4)) u_g4 (
    .clk_3(clk_3), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy[2]), .out_valid(ov[2]), .out(o[2]), .out_src(os[2]), .busy(bz[2]));

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] v;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] src;
    logic       bz;
  } vec_t;

  int          nvec = 0;
  int          nmis = 0;
  int          gaps [3] = '{2, 0, 4};
  logic [59:0] dat  [4];

  // Reference: a pointer, a cooldown count and the expected registered outputs per instance.
  int          rr   [3] = '{0, 0, 0};
  int          cool [3] = '{0, 0, 0};
  logic        ev   [3];
  logic [59:0] eo   [3];
  int          es   [3];
  bit          live = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [3:0] v);
    rst_n     = r;
    arb_en    = e;
    req_valid = v;
    for (int i = 0; i < 4; i++) req_data[i*60 +: 60] = dat[i];
  endtask

  task automatic model_pick(input int j, output logic [3:0] r, output int w);
    r = '0;
    w = -1;
    if (rst_n && arb_en && cool[j] == 0) begin
      for (int k = 0; k < 4; k++) begin
        int ix = (rr[j] + k) % 4;
        if (w < 0 && req_valid[ix]) w = ix;
      end
    end
    if (w >= 0) r[w] = 1'b1;
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next falling edge.
  task automatic step();
    logic [3:0] er;
    int         w [3];
    #1;
    for (int j = 0; j < 3; j++) begin
      model_pick(j, er, w[j]);
      chk($sformatf("g%0d_ready", gaps[j]), 64'(rdy[j]), 64'(er));
      if (live) begin
        chk($sformatf("g%0d_valid", gaps[j]), 64'(ov[j]), 64'(ev[j]));
        chk($sformatf("g%0d_out", gaps[j]), 64'(o[j]), 64'(eo[j]));
        chk($sformatf("g%0d_src", gaps[j]), 64'(os[j]), 64'(es[j]));
        chk($sformatf("g%0d_busy", gaps[j]), 64'(bz[j]), 64'(cool[j] > 0));
      end
    end
    @(posedge clk_3);
    for (int j = 0; j < 3; j++) begin
      if (!rst_n) begin
        rr[j] = 0; cool[j] = 0; ev[j] = 0; eo[j] = '0; es[j] = 0;
      end else if (w[j] >= 0) begin
        ev[j] = 1; eo[j] = dat[w[j]]; es[j] = w[j];
        rr[j] = (w[j] + 1) % 4;
        cool[j] = gaps[j];
      end else begin
        ev[j] = 0; eo[j] = '0; es[j] = 0;
        if (cool[j] > 0) cool[j]--;
      end
    end
    if (!rst_n) live = 1;
    @(negedge clk_3);
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] v, input logic [3:0] rd,
                              input logic vo, input logic [1:0] s, input logic b);
    vec_t t;
    t.rst_n = r; t.en = e; t.v = v; t.rdy = rd; t.ov = vo; t.src = s; t.bz = b;
    return t;
  endfunction

  vec_t tbl [16];

  initial begin
    dat[0] = 60'h111_2222_3333_4444;
    dat[1] = 60'h555_6666_7777_8888;
    dat[2] = 60'h0AB_CDEF_0123_4567;
    dat[3] = 60'hFED_CBA9_8765_4321;

    // pGAP=2 instance, starting from reset with rr_ptr=0.
    tbl[0]  = mk(1, 1, 4'b0100, 4'b0100, 0, 0, 0);
    tbl[1]  = mk(1, 1, 4'b0000, 4'b0000, 1, 2, 1);
    tbl[2]  = mk(1, 1, 4'b0000, 4'b0000, 0, 0, 1);
    tbl[3]  = mk(1, 1, 4'b0000, 4'b0000, 0, 0, 0);
    tbl[4]  = mk(1, 1, 4'b1111, 4'b1000, 0, 0, 0);
    tbl[5]  = mk(1, 1, 4'b1111, 4'b0000, 1, 3, 1);
    tbl[6]  = mk(1, 1, 4'b1111, 4'b0000, 0, 0, 1);
    tbl[7]  = mk(1, 1, 4'b1111, 4'b0001, 0, 0, 0);
    tbl[8]  = mk(1, 1, 4'b1111, 4'b0000, 1, 0, 1);
    tbl[9]  = mk(1, 1, 4'b1111, 4'b0000, 0, 0, 1);
    tbl[10] = mk(1, 1, 4'b1111, 4'b0010, 0, 0, 0);
    tbl[11] = mk(1, 1, 4'b1111, 4'b0000, 1, 1, 1);
    tbl[12] = mk(1, 0, 4'b0011, 4'b0000, 0, 0, 1);
    tbl[13] = mk(1, 0, 4'b0011, 4'b0000, 0, 0, 0);
    tbl[14] = mk(1, 1, 4'b0011, 4'b0001, 0, 0, 0);
    tbl[15] = mk(1, 1, 4'b0011, 4'b0000, 1, 0, 1);

    drive(0, 1, 4'b1111);
    @(negedge clk_3);

    // Reset held three cycles with every source requesting.
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 4'b1111);
      #1;
      for (int j = 0; j < 3; j++) chk("rst_ready", 64'(rdy[j]), 64'd0);
      if (c > 0) begin
        chk("rst_valid", 64'(ov[0]), 64'd0);
        chk("rst_out", 64'(o[0]), 64'd0);
        chk("rst_src", 64'(os[0]), 64'd0);
        chk("rst_busy", 64'(bz[0]), 64'd0);
      end
      step();
    end

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst_n, tbl[i].en, tbl[i].v);
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(rdy[0]), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_valid", i), 64'(ov[0]), 64'(tbl[i].ov));
      chk($sformatf("tbl%0d_src", i), 64'(os[0]), 64'(tbl[i].src));
      chk($sformatf("tbl%0d_out", i), 64'(o[0]), tbl[i].ov ? 64'(dat[tbl[i].src]) : 64'd0);
      chk($sformatf("tbl%0d_busy", i), 64'(bz[0]), 64'(tbl[i].bz));
      step();
    end

    // Back-to-back on the pGAP=0 instance with sources 1 and 3.
    drive(0, 1, 4'b0000);
    step();
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 4'b1010);
      #1;
      chk("b2b_ready", 64'(rdy[1]), (k % 2 == 0) ? 64'h2 : 64'h8);
      if (k > 0) begin
        chk("b2b_valid", 64'(ov[1]), 64'd1);
        chk("b2b_src", 64'(os[1]), (k % 2 == 1) ? 64'd1 : 64'd3);
      end
      step();
    end

    // Reset while the pGAP=4 instance is counting down.
    drive(0, 1, 4'b0000);
    step();
    drive(1, 1, 4'b0001);
    #1;
    chk("mid_accept", 64'(rdy[2]), 64'h1);
    step();
    drive(1, 1, 4'b0000);
    #1;
    chk("mid_valid", 64'(ov[2]), 64'd1);
    chk("mid_busy", 64'(bz[2]), 64'd1);
    step();
    drive(0, 1, 4'b1111);
    #1;
    chk("mid_rst_ready", 64'(rdy[2]), 64'd0);
    step();
    drive(1, 1, 4'b1010);
    #1;
    chk("mid_post_busy", 64'(bz[2]), 64'd0);
    chk("mid_post_valid", 64'(ov[2]), 64'd0);
    chk("mid_post_out", 64'(o[2]), 64'd0);
    chk("mid_post_ready", 64'(rdy[2]), 64'h2);
    step();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) dat[i] = 60'({$urandom, $urandom});
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0), 4'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
